// File: rtl/regbank_access_ctrl.sv
// Two-requester access sequencer for a 32x32 register bank: round-robin arbitration, a
// registered bank drive stage, a tagged response stage and a bulk-clear walk over every entry.
module regbank_access_ctrl #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 5,
  parameter logic [DATA_W-1:0]  CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  // Requester A
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_raddr1,
  input  logic [ADDR_W-1:0] a_raddr2,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  // Requester B
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_raddr1,
  input  logic [ADDR_W-1:0] b_raddr2,
  input  logic [ADDR_W-1:0] b_waddr,
  input  logic [DATA_W-1:0] b_wdata,
  // Tagged responses
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic [DATA_W-1:0] rsp_rdata2,
  // Bulk clear
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  // Register bank ports
  output logic [ADDR_W-1:0] bank_rreg1,
  output logic [ADDR_W-1:0] bank_rreg2,
  output logic [ADDR_W-1:0] bank_wreg,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              bank_we,
  input  logic [DATA_W-1:0] bank_rdata1,
  input  logic [DATA_W-1:0] bank_rdata2,
  // Debug: 0 = IDLE, 1 = CLEAR
  output logic              dbg_state
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;              // 0: A wins a tie, 1: B wins a tie
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;    // address currently on bank_wreg during CLEAR

  // Drive stage (cycle N+1)
  logic              s1_valid_q, s1_valid_d;
  logic              s1_id_q, s1_id_d;
  logic              s1_rd_q, s1_rd_d;
  logic [ADDR_W-1:0] rreg1_q, rreg1_d;
  logic [ADDR_W-1:0] rreg2_q, rreg2_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  // Response stage (cycle N+2)
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_rd1_q, rsp_rd1_d;
  logic [DATA_W-1:0] rsp_rd2_q, rsp_rd2_d;
  logic              clr_done_q, clr_done_d;

  // Handshake: an op transfers on a cycle where x_valid && x_ready. x_ready is a
  // combinational grant that may depend on the other side's valid; at most one
  // ready is high per cycle, and both are low in CLEAR or while clr_start is high.
  logic              accept_en;
  logic              grant_a, grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_raddr1, sel_raddr2, sel_waddr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    accept_en = (state_q == S_IDLE) && !clr_start;
    grant_a   = accept_en && a_valid && (!b_valid || !rr_q);
    grant_b   = accept_en && b_valid && (!a_valid ||  rr_q);
  end

  always_comb begin
    sel_we     = grant_b ? b_we     : a_we;
    sel_raddr1 = grant_b ? b_raddr1 : a_raddr1;
    sel_raddr2 = grant_b ? b_raddr2 : a_raddr2;
    sel_waddr  = grant_b ? b_waddr  : a_waddr;
    sel_wdata  = grant_b ? b_wdata  : a_wdata;
  end

  // Next-state for the FSM, the arbiter pointer and the drive stage.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    clr_cnt_d  = clr_cnt_q;
    s1_valid_d = 1'b0;
    s1_id_d    = s1_id_q;
    s1_rd_d    = s1_rd_q;
    rreg1_d    = rreg1_q;
    rreg2_d    = rreg2_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    clr_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          // First clear write is already on the bank in the first busy cycle.
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          wreg_d    = '0;
          wdata_d   = CLR_VALUE;
          we_d      = 1'b1;
        end else if (grant_a || grant_b) begin
          rr_d       = grant_a;
          s1_valid_d = 1'b1;
          s1_id_d    = grant_b;
          s1_rd_d    = !sel_we;
          if (sel_we) begin
            wreg_d  = sel_waddr;
            wdata_d = sel_wdata;
            we_d    = 1'b1;
          end else begin
            rreg1_d = sel_raddr1;
            rreg2_d = sel_raddr2;
          end
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          wreg_d    = clr_cnt_q + 1'b1;
          wdata_d   = CLR_VALUE;
          we_d      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response stage captures the combinational bank read at the end of the drive cycle.
  always_comb begin
    rsp_valid_d = s1_valid_q;
    rsp_id_d    = s1_id_q;
    rsp_rd1_d   = (s1_valid_q && s1_rd_q) ? bank_rdata1 : '0;
    rsp_rd2_d   = (s1_valid_q && s1_rd_q) ? bank_rdata2 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      clr_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 1'b0;
      s1_rd_q     <= 1'b0;
      rreg1_q     <= '0;
      rreg2_q     <= '0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rd1_q   <= '0;
      rsp_rd2_q   <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      clr_cnt_q   <= clr_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_rd_q     <= s1_rd_d;
      rreg1_q     <= rreg1_d;
      rreg2_q     <= rreg2_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rd1_q   <= rsp_rd1_d;
      rsp_rd2_q   <= rsp_rd2_d;
      clr_done_q  <= clr_done_d;
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_rdata1 = rsp_rd1_q;
  assign rsp_rdata2 = rsp_rd2_q;
  assign clr_busy   = (state_q == S_CLEAR);
  assign clr_done   = clr_done_q;
  assign bank_rreg1 = rreg1_q;
  assign bank_rreg2 = rreg2_q;
  assign bank_wreg  = wreg_q;
  assign bank_wdata = wdata_q;
  assign bank_we    = we_q;
  assign dbg_state  = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Bench for regbank_access_ctrl: behavioural 32x32 bank, vector table of requester ops with
// expected grants, response/bank-drive scoreboard queues, and hand-written clear/reset sequences.
module tb_regbank_access_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  // rsp entry: {due[15:0], id, rdata1, rdata2}
  localparam int EW    = 16 + 1 + DW + DW;
  // bank entry: {due[15:0], we, x1[4:0], x2[4:0], wdata}
  localparam int BW    = 16 + 1 + AW + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, a_we;
  logic [AW-1:0] a_raddr1, a_raddr2, a_waddr;
  logic [DW-1:0] a_wdata;
  logic          b_valid, b_ready, b_we;
  logic [AW-1:0] b_raddr1, b_raddr2, b_waddr;
  logic [DW-1:0] b_wdata;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_rdata1, rsp_rdata2;
  logic          clr_start, clr_busy, clr_done;
  logic [AW-1:0] bank_rreg1, bank_rreg2, bank_wreg;
  logic [DW-1:0] bank_wdata;
  logic          bank_we;
  logic [DW-1:0] bank_rdata1, bank_rdata2;
  logic          dbg_state;

  regbank_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CLR_VALUE('0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
    .a_raddr1(a_raddr1), .a_raddr2(a_raddr2), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
    .b_raddr1(b_raddr1), .b_raddr2(b_raddr2), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .bank_rreg1(bank_rreg1), .bank_rreg2(bank_rreg2), .bank_wreg(bank_wreg),
    .bank_wdata(bank_wdata), .bank_we(bank_we),
    .bank_rdata1(bank_rdata1), .bank_rdata2(bank_rdata2),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int          cyc = 0;
  logic [EW-1:0] rsp_q[$];
  logic [BW-1:0] bank_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      rsp_q.delete();
      bank_q.delete();
    end
  end

  // ---------------- behavioural register bank ----------------
  logic          bank_load;
  logic [DW-1:0] bank_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];

  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < DEPTH; i++) bank_mem[i] <= 32'h1000 + i;
    end else if (bank_we) begin
      bank_mem[bank_wreg] <= bank_wdata;
    end
  end
  assign bank_rdata1 = bank_mem[bank_rreg1];
  assign bank_rdata2 = bank_mem[bank_rreg2];

  // ---------------- check helper ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    else n_pass++;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          mon_en = 1'b0;
  logic [EW-1:0] mon_e;
  logic [BW-1:0] mon_b;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_q.size() > 0 && rsp_q[0][EW-1 -: 16] == 16'(cyc)) begin
        mon_e = rsp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(mon_e[2*DW]));
        check("rsp_rdata1", 64'(rsp_rdata1), 64'(mon_e[2*DW-1:DW]));
        check("rsp_rdata2", 64'(rsp_rdata2), 64'(mon_e[DW-1:0]));
      end else begin
        check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      end
      if (bank_q.size() > 0 && bank_q[0][BW-1 -: 16] == 16'(cyc)) begin
        mon_b = bank_q.pop_front();
        if (mon_b[DW+2*AW]) begin
          check("bank_we_wr", 64'(bank_we), 64'd1);
          check("bank_wreg", 64'(bank_wreg), 64'(mon_b[DW+2*AW-1 -: AW]));
          check("bank_wdata", 64'(bank_wdata), 64'(mon_b[DW-1:0]));
        end else begin
          check("bank_we_rd", 64'(bank_we), 64'd0);
          check("bank_rreg1", 64'(bank_rreg1), 64'(mon_b[DW+2*AW-1 -: AW]));
          check("bank_rreg2", 64'(bank_rreg2), 64'(mon_b[DW+AW-1 -: AW]));
        end
      end else begin
        check("bank_we_idle", 64'(bank_we), 64'd0);
      end
    end
  end

  // ---------------- stimulus vectors ----------------
  typedef struct {
    logic          rst, clr;
    logic          av, awe;
    logic [AW-1:0] ar1, ar2, awa;
    logic [DW-1:0] awd;
    logic          bv, bwe;
    logic [AW-1:0] br1, br2, bwa;
    logic [DW-1:0] bwd;
    logic          exp_ar, exp_br;
  } vec_t;

  function automatic vec_t v_idle();
    vec_t v;
    v.rst = 0; v.clr = 0;
    v.av = 0; v.awe = 0; v.ar1 = 0; v.ar2 = 0; v.awa = 0; v.awd = 0;
    v.bv = 0; v.bwe = 0; v.br1 = 0; v.br2 = 0; v.bwa = 0; v.bwd = 0;
    v.exp_ar = 0; v.exp_br = 0;
    return v;
  endfunction

  function automatic vec_t v_rst();
    vec_t v = v_idle();
    v.rst = 1;
    return v;
  endfunction

  // side 0 = A, 1 = B; for a write x1 is the write address
  function automatic vec_t add_op(input vec_t vi, input logic side, input logic we,
                                  input logic [AW-1:0] x1, input logic [AW-1:0] x2,
                                  input logic [DW-1:0] wd);
    vec_t v = vi;
    if (!side) begin
      v.av = 1; v.awe = we; v.ar1 = x1; v.ar2 = x2; v.awa = x1; v.awd = wd;
    end else begin
      v.bv = 1; v.bwe = we; v.br1 = x1; v.br2 = x2; v.bwa = x1; v.bwd = wd;
    end
    return v;
  endfunction

  function automatic vec_t exp_rdy(input vec_t vi, input logic ea, input logic eb);
    vec_t v = vi;
    v.exp_ar = ea; v.exp_br = eb;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic accept(input logic id, input logic we, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (we) begin
      ref_mem[wa] = wd;
      rsp_q.push_back({16'(cyc + 2), id, 32'h0, 32'h0});
      bank_q.push_back({16'(cyc + 1), 1'b1, wa, 5'h0, wd});
    end else begin
      rsp_q.push_back({16'(cyc + 2), id, ref_mem[r1], ref_mem[r2]});
      bank_q.push_back({16'(cyc + 1), 1'b0, r1, r2, 32'h0});
    end
  endtask

  task automatic drive_inputs(input vec_t v);
    rst = v.rst; clr_start = v.clr;
    a_valid = v.av; a_we = v.awe; a_raddr1 = v.ar1; a_raddr2 = v.ar2; a_waddr = v.awa; a_wdata = v.awd;
    b_valid = v.bv; b_we = v.bwe; b_raddr1 = v.br1; b_raddr2 = v.br2; b_waddr = v.bwa; b_wdata = v.bwd;
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    drive_inputs(v);
    @(negedge clk);
    check("a_ready", 64'(a_ready), 64'(v.exp_ar));
    check("b_ready", 64'(b_ready), 64'(v.exp_br));
    if (!v.rst && v.exp_ar)      accept(1'b0, v.awe, v.ar1, v.ar2, v.awa, v.awd);
    else if (!v.rst && v.exp_br) accept(1'b1, v.bwe, v.br1, v.br2, v.bwa, v.bwd);
  endtask

  // Full clear with both requesters waiting; clr_start re-pulsed mid-clear must be ignored.
  task automatic clear_full();
    vec_t v;
    int   t;
    v = add_op(add_op(v_idle(), 1'b0, 1'b0, 5'd10, 5'd31, 32'h0), 1'b1, 1'b1, 5'd4, 5'd0, 32'hbad);
    v.clr = 1;
    @(posedge clk); #1;
    drive_inputs(v);
    @(negedge clk);
    check("clr_a_ready", 64'(a_ready), 64'd0);
    check("clr_b_ready", 64'(b_ready), 64'd0);
    check("clr_busy_start", 64'(clr_busy), 64'd0);
    t = cyc;
    for (int k = 0; k < DEPTH; k++) bank_q.push_back({16'(t + 1 + k), 1'b1, 5'(k), 5'h0, 32'h0});
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      clr_start = (k == 5);
      @(negedge clk);
      check("clr_busy", 64'(clr_busy), 64'd1);
      check("clr_done_early", 64'(clr_done), 64'd0);
      check("busy_a_ready", 64'(a_ready), 64'd0);
      check("busy_b_ready", 64'(b_ready), 64'd0);
      check("dbg_state_clear", 64'(dbg_state), 64'd1);
    end
    @(posedge clk); #1;
    clr_start = 0; b_valid = 0;
    @(negedge clk);
    check("clr_done", 64'(clr_done), 64'd1);
    check("clr_busy_end", 64'(clr_busy), 64'd0);
    check("post_clr_a_ready", 64'(a_ready), 64'd1);
    accept(1'b0, 1'b0, 5'd10, 5'd31, 5'd0, 32'h0);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk);
    check("clr_done_pulse", 64'(clr_done), 64'd0);
  endtask

  // Reset during the 10th busy cycle: clear aborts with no clr_done, requests resume.
  task automatic clear_reset();
    int t;
    apply(exp_rdy(add_op(v_idle(), 1'b0, 1'b1, 5'd5,  5'd0, 32'd55), 1'b1, 1'b0));
    apply(exp_rdy(add_op(v_idle(), 1'b0, 1'b1, 5'd20, 5'd0, 32'd77), 1'b1, 1'b0));
    apply(v_idle());
    apply(v_idle());
    @(posedge clk); #1;
    drive_inputs(v_idle());
    clr_start = 1;
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < 10; k++) bank_q.push_back({16'(t + 1 + k), 1'b1, 5'(k), 5'h0, 32'h0});
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      clr_start = 0;
      rst = (k == 9);
      @(negedge clk);
      check("rclr_busy", 64'(clr_busy), 64'd1);
    end
    for (int i = 0; i < 10; i++) ref_mem[i] = 32'h0;
    @(posedge clk); #1;
    drive_inputs(add_op(v_idle(), 1'b0, 1'b0, 5'd5, 5'd20, 32'h0));
    @(negedge clk);
    check("rclr_busy_off", 64'(clr_busy), 64'd0);
    check("rclr_bank_we", 64'(bank_we), 64'd0);
    check("rclr_no_done", 64'(clr_done), 64'd0);
    check("rclr_a_ready", 64'(a_ready), 64'd1);
    accept(1'b0, 1'b0, 5'd5, 5'd20, 5'd0, 32'h0);
    @(posedge clk); #1;
    drive_inputs(v_idle());
    @(negedge clk);
    check("rclr_no_done2", 64'(clr_done), 64'd0);
  endtask

  // ---------------- main test ----------------
  vec_t tbl[$];

  initial begin
    vec_t v;
    logic rr_m, ga, gb;

    drive_inputs(v_rst());
    bank_load = 1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h1000 + i;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata1", 64'(rsp_rdata1), 64'd0);
    check("rst_bank_we", 64'(bank_we), 64'd0);
    check("rst_bank_wreg", 64'(bank_wreg), 64'd0);
    check("rst_bank_rreg1", 64'(bank_rreg1), 64'd0);
    check("rst_clr_busy", 64'(clr_busy), 64'd0);
    check("rst_clr_done", 64'(clr_done), 64'd0);
    check("rst_dbg_state", 64'(dbg_state), 64'd0);
    bank_load = 0;
    mon_en = 1;

    // Write then read-back, RR pairs, RAW, B-alone streaming, same-address ordering, reset drop.
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 1, 5'd3, 5'd0, 32'd100), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd3, 5'd0, 32'd0), 1, 0));
    tbl.push_back(v_idle());
    tbl.push_back(v_idle());
    tbl.push_back(v_rst());
    tbl.push_back(exp_rdy(add_op(add_op(v_idle(), 0, 0, 5'd1,  5'd2,  0), 1, 0, 5'd6,  5'd7,  0), 1, 0));
    tbl.push_back(exp_rdy(add_op(add_op(v_idle(), 0, 0, 5'd4,  5'd5,  0), 1, 0, 5'd8,  5'd9,  0), 0, 1));
    tbl.push_back(exp_rdy(add_op(add_op(v_idle(), 0, 0, 5'd11, 5'd12, 0), 1, 0, 5'd13, 5'd14, 0), 1, 0));
    tbl.push_back(exp_rdy(add_op(add_op(v_idle(), 0, 0, 5'd15, 5'd16, 0), 1, 0, 5'd17, 5'd18, 0), 0, 1));
    tbl.push_back(exp_rdy(add_op(v_idle(), 1, 1, 5'd10, 5'd0,  32'd250), 0, 1));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd10, 5'd3,  32'd0), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 1, 1, 5'd31, 5'd0,  32'hdeadbeef), 0, 1));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd31, 5'd10, 32'd0), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 1, 0, 5'd3,  5'd31, 32'd0), 0, 1));
    tbl.push_back(exp_rdy(add_op(v_idle(), 1, 0, 5'd10, 5'd0,  32'd0), 0, 1));
    tbl.push_back(exp_rdy(add_op(v_idle(), 1, 1, 5'd0,  5'd0,  32'd5), 0, 1));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd0,  5'd0,  32'd0), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd12, 5'd12, 32'd0), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 1, 5'd12, 5'd0,  32'h1234), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd12, 5'd1,  32'd0), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd1,  5'd2,  32'd0), 1, 0));
    tbl.push_back(v_rst());
    tbl.push_back(v_idle());
    tbl.push_back(exp_rdy(add_op(add_op(v_idle(), 0, 1, 5'd7, 5'd0, 32'h77), 1, 0, 5'd7, 5'd7, 0), 1, 0));
    tbl.push_back(exp_rdy(add_op(add_op(v_idle(), 0, 1, 5'd8, 5'd0, 32'h88), 1, 0, 5'd7, 5'd7, 0), 0, 1));
    tbl.push_back(exp_rdy(add_op(add_op(v_idle(), 0, 1, 5'd8, 5'd0, 32'h88), 1, 0, 5'd8, 5'd7, 0), 1, 0));
    tbl.push_back(exp_rdy(add_op(v_idle(), 1, 0, 5'd8, 5'd7, 32'd0), 0, 1));
    tbl.push_back(v_idle());
    tbl.push_back(exp_rdy(add_op(v_idle(), 0, 0, 5'd3, 5'd31, 32'd0), 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    clear_full();
    apply(exp_rdy(add_op(v_idle(), 1, 0, 5'd31, 5'd10, 32'd0), 0, 1));
    apply(v_idle());
    apply(v_idle());

    clear_reset();
    apply(v_idle());
    apply(v_idle());

    // Random traffic against a round-robin model, starting from reset (A has priority).
    apply(v_rst());
    rr_m = 1'b0;
    for (int n = 0; n < 160; n++) begin
      v = v_idle();
      if ($urandom_range(0, 3) != 0)
        v = add_op(v, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), $urandom_range(0, 32'hffff));
      if ($urandom_range(0, 3) != 0)
        v = add_op(v, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), $urandom_range(0, 32'hffff));
      ga = v.av && (!v.bv || !rr_m);
      gb = v.bv && (!v.av ||  rr_m);
      if (ga)      rr_m = 1'b1;
      else if (gb) rr_m = 1'b0;
      apply(exp_rdy(v, ga, gb));
    end
    repeat (3) apply(v_idle());

    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    check("bank_q_drained", 64'(bank_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
